spine_egress_buffer: RTL and testbench

SPINE_EGRESS_BUFFER -- requirements
Module: spine_egress_buffer

---
 rtl/spine_pkg.sv | 19 +
 rtl/spine_sync_fifo.sv | 45 ++++
 rtl/spine_egress_buffer.sv | 122 ++++++++++++
 tb/tb_spine_egress_buffer.sv | 174 +++++++++++++++++
 4 files changed

// File: rtl/spine_pkg.sv
// Shared types and defaults for the spine egress path.
package spine_pkg;

    localparam int SPINE_DWIDTH = 16;

    // Output register state: IDLE = empty, SEND = first cycle of a flit,
    // STALL = flit held for at least one cycle with the link not ready.
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SEND  = 2'd1,
        STALL = 2'd2
    } out_state_e;

    // 16-bit counter increment that sticks at all-ones.
    function automatic logic [15:0] sat_inc16(input logic [15:0] v);
        return (v == 16'hFFFF) ? v : v + 16'd1;
    endfunction

endpackage

// File: rtl/spine_sync_fifo.sv
// Circular FIFO storage for the egress buffer: wrapping pointers plus an
// occupancy counter. The caller never pushes when full or pops when empty.
module spine_sync_fifo #(
    parameter int DWIDTH = 16,
    parameter int DEPTH  = 8
) (
    input  logic                     clk_i,
    input  logic                     reset_i,
    input  logic                     push_i,
    input  logic [DWIDTH-1:0]        wdata_i,
    input  logic                     pop_i,
    output logic [DWIDTH-1:0]        rdata_o,
    output logic [$clog2(DEPTH):0]   level_o,
    output logic                     full_o
);
    localparam int AW = $clog2(DEPTH);
    localparam int LW = AW + 1;

    logic [DWIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]     wr_ptr_q, rd_ptr_q;
    logic [LW-1:0]     level_q;

    // Storage array: written at the tail, no reset needed.
    always_ff @(posedge clk_i) begin
        if (push_i) mem_q[wr_ptr_q] <= wdata_i;
    end

    // Pointers wrap naturally because DEPTH is a power of two.
    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            level_q  <= '0;
        end else begin
            if (push_i) wr_ptr_q <= wr_ptr_q + AW'(1);
            if (pop_i)  rd_ptr_q <= rd_ptr_q + AW'(1);
            level_q <= level_q + LW'(push_i) - LW'(pop_i);
        end
    end

    assign rdata_o = mem_q[rd_ptr_q];
    assign level_o = level_q;
    assign full_o  = (level_q == LW'(DEPTH));

endmodule

// File: rtl/spine_egress_buffer.sv
// Egress buffer between a spine router output port and its link: a
// DEPTH-entry FIFO followed by one output register driven by a small FSM.
// Optional stats counters are built when SPINE_EGRESS_STATS_EN is defined.
module spine_egress_buffer
    import spine_pkg::*;
#(
    parameter int          DWIDTH  = SPINE_DWIDTH,
    parameter int          DEPTH   = 8,
    parameter logic [3:0]  PORT_ID = 4'd1
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic [DWIDTH-1:0]        in_data,
    input  logic                     in_valid,
    output logic                     fifo_full,
    output logic [DWIDTH-1:0]        out_data,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [$clog2(DEPTH):0]   level,
`ifdef SPINE_EGRESS_STATS_EN
    output logic [15:0]              flit_count,
    output logic [15:0]              stall_count,
`endif
    output logic                     overflow_err
);
    logic [$clog2(DEPTH):0] level_w;
    logic [DWIDTH-1:0]      head_w;
    logic                   full_w;

    out_state_e        state_q;
    logic              out_valid_q;
    logic [DWIDTH-1:0] out_data_q;
    logic              overflow_q;

    logic accept, hs, can_load, pop, bypass, push, load;
    logic [DWIDTH-1:0] load_data;

    // Full comes from registered level only, so a write on a popping edge
    // while full is still dropped.
    assign accept    = in_valid & ~full_w;
    assign hs        = out_valid_q & out_ready;
    assign can_load  = ~out_valid_q | hs;
    assign pop       = can_load & (level_w != '0);
    assign bypass    = can_load & (level_w == '0) & accept;
    assign push      = accept & ~bypass;
    assign load      = pop | bypass;
    assign load_data = pop ? head_w : in_data;

    spine_sync_fifo #(
        .DWIDTH (DWIDTH),
        .DEPTH  (DEPTH)
    ) u_fifo (
        .clk_i   (clk),
        .reset_i (reset),
        .push_i  (push),
        .wdata_i (in_data),
        .pop_i   (pop),
        .rdata_o (head_w),
        .level_o (level_w),
        .full_o  (full_w)
    );

    // Output FSM with registered out_valid/out_data and sticky overflow flag.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= IDLE;
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
            overflow_q  <= 1'b0;
        end else begin
            if (in_valid & full_w) overflow_q <= 1'b1;
            case (state_q)
                IDLE: begin
                    if (load) begin
                        state_q     <= SEND;
                        out_valid_q <= 1'b1;
                        out_data_q  <= load_data;
                    end
                end
                default: begin
                    if (hs) begin
                        if (load) begin
                            state_q     <= SEND;
                            out_valid_q <= 1'b1;
                            out_data_q  <= load_data;
                        end else begin
                            state_q     <= IDLE;
                            out_valid_q <= 1'b0;
                        end
                    end else begin
                        state_q <= STALL;
                    end
                end
            endcase
        end
    end

`ifdef SPINE_EGRESS_STATS_EN
    logic [15:0] flit_cnt_q, stall_cnt_q;

    // Saturating counters: handshakes and cycles spent in STALL.
    always_ff @(posedge clk) begin
        if (reset) begin
            flit_cnt_q  <= '0;
            stall_cnt_q <= '0;
        end else begin
            if (hs)               flit_cnt_q  <= sat_inc16(flit_cnt_q);
            if (state_q == STALL) stall_cnt_q <= sat_inc16(stall_cnt_q);
        end
    end

    assign flit_count  = flit_cnt_q;
    assign stall_count = stall_cnt_q;
`endif

    assign fifo_full    = full_w;
    assign level        = level_w;
    assign out_valid    = out_valid_q;
    assign out_data     = out_data_q;
    assign overflow_err = overflow_q;

endmodule

// File: tb/tb_spine_egress_buffer.sv
// Bench for spine_egress_buffer: directed scenarios followed by random
// traffic, compared each cycle against a queue model of all held flits.
module tb_spine_egress_buffer;
    import spine_pkg::*;

    localparam int DW    = 16;
    localparam int DEPTH = 8;

    logic          clk, reset, in_valid, out_ready;
    logic [DW-1:0] in_data, out_data;
    logic          fifo_full, out_valid, overflow_err;
    logic [3:0]    level;
`ifdef SPINE_EGRESS_STATS_EN
    logic [15:0]   flit_count, stall_count;
`endif

    spine_egress_buffer #(.DWIDTH(DW), .DEPTH(DEPTH), .PORT_ID(4'd1)) dut (
        .clk          (clk),
        .reset        (reset),
        .in_data      (in_data),
        .in_valid     (in_valid),
        .fifo_full    (fifo_full),
        .out_data     (out_data),
        .out_valid    (out_valid),
        .out_ready    (out_ready),
        .level        (level),
`ifdef SPINE_EGRESS_STATS_EN
        .flit_count   (flit_count),
        .stall_count  (stall_count),
`endif
        .overflow_err (overflow_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // Model: every flit held (FIFO + output register), oldest first.
    logic [DW-1:0] q[$];
    bit ovf_m;
    bit stalled_m;
    int flit_m, stall_m;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic compare_all();
        int sz;
        sz = q.size();
        chk("out_valid", 32'(out_valid), 32'(sz > 0));
        if (sz > 0) chk("out_data", 32'(out_data), 32'(q[0]));
        chk("level", 32'(level), (sz > 0) ? sz - 1 : 0);
        chk("fifo_full", 32'(fifo_full), 32'(sz == DEPTH + 1));
        chk("overflow_err", 32'(overflow_err), 32'(ovf_m));
`ifdef SPINE_EGRESS_STATS_EN
        chk("flit_count", 32'(flit_count), (flit_m > 65535) ? 65535 : flit_m);
        chk("stall_count", 32'(stall_count), (stall_m > 65535) ? 65535 : stall_m);
`endif
    endtask

    // One clock: drive inputs, advance the model on the edge, check after it.
    task automatic step(input bit rst, input bit iv, input logic [DW-1:0] d, input bit ordy);
        bit full, hs;
        reset = rst; in_valid = iv; in_data = d; out_ready = ordy;
        @(posedge clk);
        if (rst) begin
            q.delete();
            ovf_m = 0; stalled_m = 0; flit_m = 0; stall_m = 0;
        end else begin
            full = (q.size() == DEPTH + 1);
            hs   = (q.size() > 0) && ordy;
            if (stalled_m) stall_m++;
            stalled_m = (q.size() > 0) && !ordy;
            if (hs) begin
                void'(q.pop_front());
                flit_m++;
            end
            if (iv) begin
                if (full) ovf_m = 1;
                else      q.push_back(d);
            end
        end
        #1;
        compare_all();
    endtask

    initial begin
        reset = 1'b1; in_valid = 1'b0; in_data = '0; out_ready = 1'b0;
        q.delete(); ovf_m = 0; stalled_m = 0; flit_m = 0; stall_m = 0;

        // Reset state
        step(1, 0, 16'h0, 0);
        step(1, 0, 16'h0, 0);
        chk("rst_out_data", 32'(out_data), 32'h0);
        step(0, 0, 16'h0, 0);

        // Single flit: latency 1, then idle
        step(0, 1, 16'hA5C3, 1);
        chk("single_data", 32'(out_data), 32'hA5C3);
        chk("single_valid", 32'(out_valid), 32'h1);
        step(0, 0, 16'h0, 1);
        chk("single_idle", 32'(out_valid), 32'h0);

        // Fill: 9 flits with link stalled
        for (int i = 1; i <= 9; i++) step(0, 1, 16'(i), 0);
        chk("fill_head", 32'(out_data), 32'h1);
        chk("fill_level", 32'(level), 32'd8);
        chk("fill_full", 32'(fifo_full), 32'h1);
        chk("fill_ovf", 32'(overflow_err), 32'h0);

        // Overflow: dropped write, sticky flag, in-order drain
        step(0, 1, 16'h00FF, 0);
        chk("ovf_set", 32'(overflow_err), 32'h1);
        chk("ovf_level", 32'(level), 32'd8);
        for (int i = 1; i <= 9; i++) begin
            chk("drain_order", 32'(out_data), 32'(i));
            step(0, 0, 16'h0, 1);
        end
        chk("drain_empty", 32'(out_valid), 32'h0);
        chk("ovf_sticky", 32'(overflow_err), 32'h1);

        // Stall: five cycles of out_ready=0 on one flit
        step(1, 0, 16'h0, 0);
        step(0, 1, 16'h1234, 0);
        for (int i = 0; i < 5; i++) begin
            step(0, 0, 16'h0, 0);
            chk("stall_data", 32'(out_data), 32'h1234);
        end
        chk("stall_state", 32'(dut.state_q), 32'(STALL));
`ifdef SPINE_EGRESS_STATS_EN
        chk("stall_count4", 32'(stall_count), 32'd4);
`endif
        step(0, 0, 16'h0, 1);

        // Simultaneous write + handshake with level 3
        step(1, 0, 16'h0, 0);
        for (int i = 0; i < 4; i++) step(0, 1, 16'(16'h100 + i), 0);
        chk("sim_level0", 32'(level), 32'd3);
        for (int i = 0; i < 10; i++) begin
            step(0, 1, 16'(16'h200 + i), 1);
            chk("sim_level", 32'(level), 32'd3);
        end
        for (int i = 0; i < 4; i++) step(0, 0, 16'h0, 1);

        // Mid-operation reset with a same-edge write
        for (int i = 0; i < 6; i++) step(0, 1, 16'(16'h300 + i), 0);
        chk("mid_level5", 32'(level), 32'd5);
        step(1, 1, 16'hBEEF, 1);
        chk("mid_valid", 32'(out_valid), 32'h0);
        chk("mid_level", 32'(level), 32'd0);
        chk("mid_full", 32'(fifo_full), 32'h0);
        step(0, 0, 16'h0, 1);
        chk("mid_ignored", 32'(out_valid), 32'h0);

        // Random traffic
        for (int i = 0; i < 600; i++) begin
            step($urandom_range(199) == 0,
                 $urandom_range(99) < 60,
                 16'($urandom),
                 $urandom_range(99) < 45);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
